// File: rtl/rx_fc_credit_manager_pkg.sv
// Shared FC types and credit helpers for the Rx credit manager and its counters.
// Pure package: no logic, no latency, no backpressure.
package rx_fc_credit_manager_pkg;

    typedef enum logic [1:0] {
        FC_P   = 2'd0,
        FC_NP  = 2'd1,
        FC_CPL = 2'd2,
        FC_X   = 2'd3
    } fc_type_e;

    typedef enum logic {
        S_INIT   = 1'b0,
        S_ACTIVE = 1'b1
    } fc_state_e;

    localparam int TLP_DW_WIDTH = 11;

    function automatic logic [9:0] fc_dw_to_credits(input logic [TLP_DW_WIDTH-1:0] dw);
        logic [11:0] sum;
        sum = {1'b0, dw} + 12'd3;
        return sum[11:2];
    endfunction

    function automatic logic [2:0] fc_onehot(input fc_type_e t);
        case (t)
            FC_P:    return 3'b001;
            FC_NP:   return 3'b010;
            FC_CPL:  return 3'b100;
            default: return 3'b000;
        endcase
    endfunction

    function automatic fc_type_e fc_next(input fc_type_e t);
        case (t)
            FC_P:    return FC_NP;
            FC_NP:   return FC_CPL;
            default: return FC_P;
        endcase
    endfunction

endpackage

// File: rtl/rx_fc_credit_manager_if.sv
// FC advertisement channel towards the Data Link Layer (valid/ready).
// master = credit manager, slave = DLL; value holds while valid && !ready.
interface rx_fc_credit_manager_if #(
    parameter int HW = 12,
    parameter int DW = 16
);
    import rx_fc_credit_manager_pkg::*;

    logic          fc_valid;
    logic          fc_ready;
    logic          fc_init;
    fc_type_e      fc_type;
    logic [HW-1:0] fc_hdr;
    logic [DW-1:0] fc_data;

    modport master (output fc_valid, fc_init, fc_type, fc_hdr, fc_data, input fc_ready);
    modport slave  (input fc_valid, fc_init, fc_type, fc_hdr, fc_data, output fc_ready);
endinterface

// File: rtl/rx_fc_credit_counter.sv
// Per-type CA/CR header+data counters with the receiver overflow compare.
// CA/CR update one cycle after rx/release; o_ovf is combinational on the incoming TLP; no backpressure.
module rx_fc_credit_counter
    import rx_fc_credit_manager_pkg::*;
#(
    parameter int HW        = 12,
    parameter int DW        = 16,
    parameter int INIT_HDR  = 30,
    parameter int INIT_DATA = 1000
) (
    input  logic                    clk,
    input  logic                    arst,
    input  logic                    i_rx_vld,
    input  logic [TLP_DW_WIDTH-1:0] i_rx_dw,
    input  logic                    i_rel_vld,
    input  logic [TLP_DW_WIDTH-1:0] i_rel_dw,
    output logic [HW-1:0]           o_ca_hdr,
    output logic [DW-1:0]           o_ca_data,
    output logic                    o_ovf
);
    localparam bit            HDR_FIN  = (INIT_HDR != 0);
    localparam bit            DAT_FIN  = (INIT_DATA != 0);
    localparam logic [HW-1:0] HDR_HALF = {1'b1, {(HW-1){1'b0}}};
    localparam logic [DW-1:0] DAT_HALF = {1'b1, {(DW-1){1'b0}}};

    logic [HW-1:0] r_ca_hdr, r_cr_hdr, w_cr_hdr_nxt, w_hdr_room;
    logic [DW-1:0] r_ca_data, r_cr_data, w_cr_data_nxt, w_data_room;
    logic [DW-1:0] w_rx_cost, w_rel_cost;

    assign w_rx_cost     = DW'(fc_dw_to_credits(i_rx_dw));
    assign w_rel_cost    = DW'(fc_dw_to_credits(i_rel_dw));
    assign w_cr_hdr_nxt  = r_cr_hdr + HW'(1);
    assign w_cr_data_nxt = r_cr_data + w_rx_cost;

    // Room left after this TLP; above half range means CR has passed CA.
    assign w_hdr_room  = r_ca_hdr - w_cr_hdr_nxt;
    assign w_data_room = r_ca_data - w_cr_data_nxt;
    assign o_ovf = i_rx_vld && ((HDR_FIN && (w_hdr_room > HDR_HALF)) ||
                                (DAT_FIN && (w_data_room > DAT_HALF)));

    always_ff @(posedge clk) begin
        if (arst) begin
            r_ca_hdr  <= HW'(INIT_HDR);
            r_ca_data <= DW'(INIT_DATA);
            r_cr_hdr  <= '0;
            r_cr_data <= '0;
        end else begin
            if (i_rx_vld) begin
                r_cr_hdr  <= w_cr_hdr_nxt;
                r_cr_data <= w_cr_data_nxt;
            end
            if (i_rel_vld && HDR_FIN) r_ca_hdr  <= r_ca_hdr + HW'(1);
            if (i_rel_vld && DAT_FIN) r_ca_data <= r_ca_data + w_rel_cost;
        end
    end

    assign o_ca_hdr  = r_ca_hdr;
    assign o_ca_data = r_ca_data;
endmodule

// File: rtl/rx_fc_credit_manager.sv
// Rx FC credit manager: InitFC rotation, then UpdateFC P>NP>CPL; optional refresh timer via RX_FC_UPDATE_TIMER_EN.
// Release->fc_valid >= 2 cycles, TLP->overflow 1 cycle; presented value held while fc_ready low.
module rx_fc_credit_manager
    import rx_fc_credit_manager_pkg::*;
#(
    parameter int FC_HDR_WIDTH  = 12,
    parameter int FC_DATA_WIDTH = 16,
    parameter int INIT_P_HDR    = 30,
    parameter int INIT_NP_HDR   = 15,
    parameter int INIT_CPL_HDR  = 30,
    parameter int INIT_P_DATA   = 1000,
    parameter int INIT_NP_DATA  = 1000,
    parameter int INIT_CPL_DATA = 1000,
    parameter int UPDATE_PERIOD = 1024
) (
    input  logic                    clk,
    input  logic                    arst,
    input  logic                    rx_tlp_valid,
    input  fc_type_e                rx_tlp_type,
    input  logic [TLP_DW_WIDTH-1:0] rx_tlp_dw,
    input  logic                    rel_valid,
    input  fc_type_e                rel_type,
    input  logic [TLP_DW_WIDTH-1:0] rel_dw,
    input  logic                    fc_init_done,
    output logic                    fc_overflow,
    output fc_type_e                fc_overflow_type,
    rx_fc_credit_manager_if.master  fc_if
);
    localparam logic [2:0] FIN_MASK = {(INIT_CPL_HDR != 0) || (INIT_CPL_DATA != 0),
                                       (INIT_NP_HDR  != 0) || (INIT_NP_DATA  != 0),
                                       (INIT_P_HDR   != 0) || (INIT_P_DATA   != 0)};

    logic [3:0][FC_HDR_WIDTH-1:0]  w_ca_hdr;
    logic [3:0][FC_DATA_WIDTH-1:0] w_ca_data;
    logic [2:0] w_ovf, r_pend, w_hs_mask, w_rel_set, w_timer_set, w_avail;
    fc_state_e  r_state, w_state_nxt;
    fc_type_e   r_ptr, w_ptr_nxt;
    logic       w_hs, w_free;

    logic                     r_fc_valid, r_fc_init, w_fc_valid_nxt, w_fc_init_nxt;
    fc_type_e                 r_fc_type, w_fc_type_nxt;
    logic [FC_HDR_WIDTH-1:0]  r_fc_hdr, w_fc_hdr_nxt;
    logic [FC_DATA_WIDTH-1:0] r_fc_data, w_fc_data_nxt;
    logic                     r_ovf;
    fc_type_e                 r_ovf_type;

    rx_fc_credit_counter #(.HW(FC_HDR_WIDTH), .DW(FC_DATA_WIDTH), .INIT_HDR(INIT_P_HDR), .INIT_DATA(INIT_P_DATA)) u_cnt_p (
        .clk(clk), .arst(arst),
        .i_rx_vld(rx_tlp_valid && (rx_tlp_type == FC_P)), .i_rx_dw(rx_tlp_dw),
        .i_rel_vld(rel_valid && (rel_type == FC_P)), .i_rel_dw(rel_dw),
        .o_ca_hdr(w_ca_hdr[0]), .o_ca_data(w_ca_data[0]), .o_ovf(w_ovf[0]));
    rx_fc_credit_counter #(.HW(FC_HDR_WIDTH), .DW(FC_DATA_WIDTH), .INIT_HDR(INIT_NP_HDR), .INIT_DATA(INIT_NP_DATA)) u_cnt_np (
        .clk(clk), .arst(arst),
        .i_rx_vld(rx_tlp_valid && (rx_tlp_type == FC_NP)), .i_rx_dw(rx_tlp_dw),
        .i_rel_vld(rel_valid && (rel_type == FC_NP)), .i_rel_dw(rel_dw),
        .o_ca_hdr(w_ca_hdr[1]), .o_ca_data(w_ca_data[1]), .o_ovf(w_ovf[1]));
    rx_fc_credit_counter #(.HW(FC_HDR_WIDTH), .DW(FC_DATA_WIDTH), .INIT_HDR(INIT_CPL_HDR), .INIT_DATA(INIT_CPL_DATA)) u_cnt_cpl (
        .clk(clk), .arst(arst),
        .i_rx_vld(rx_tlp_valid && (rx_tlp_type == FC_CPL)), .i_rx_dw(rx_tlp_dw),
        .i_rel_vld(rel_valid && (rel_type == FC_CPL)), .i_rel_dw(rel_dw),
        .o_ca_hdr(w_ca_hdr[2]), .o_ca_data(w_ca_data[2]), .o_ovf(w_ovf[2]));
    assign w_ca_hdr[3]  = '0;
    assign w_ca_data[3] = '0;

`ifdef RX_FC_UPDATE_TIMER_EN
    localparam int TMR_W = (UPDATE_PERIOD > 1) ? $clog2(UPDATE_PERIOD) : 1;
    logic [TMR_W-1:0] r_tmr;
    logic             w_tmr_expire;
    assign w_tmr_expire = (r_state == S_ACTIVE) && (r_tmr == TMR_W'(UPDATE_PERIOD - 1));
    always_ff @(posedge clk) begin
        if (arst || (r_state != S_ACTIVE) || w_tmr_expire) r_tmr <= '0;
        else                                               r_tmr <= r_tmr + TMR_W'(1);
    end
    assign w_timer_set = w_tmr_expire ? FIN_MASK : 3'b000;
`else
    logic w_unused_period;
    assign w_unused_period = (UPDATE_PERIOD != 0);
    assign w_timer_set     = 3'b000;
`endif

    assign w_hs      = r_fc_valid && fc_if.fc_ready;
    assign w_free    = !r_fc_valid || fc_if.fc_ready;
    assign w_hs_mask = (w_hs && !r_fc_init) ? fc_onehot(r_fc_type) : 3'b000;
    assign w_rel_set = rel_valid ? (fc_onehot(rel_type) & FIN_MASK) : 3'b000;
    // A type just accepted is not eligible again this cycle; a same-cycle release re-arms it.
    assign w_avail   = r_pend & ~w_hs_mask;
    assign w_ptr_nxt = (w_hs && r_fc_init) ? fc_next(r_ptr) : r_ptr;

    always_ff @(posedge clk) begin
        if (arst) begin
            r_state <= S_INIT;
            r_ptr   <= FC_P;
            r_pend  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_ptr   <= w_ptr_nxt;
            r_pend  <= w_avail | w_rel_set | w_timer_set;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        if ((r_state == S_INIT) && fc_init_done && w_free) w_state_nxt = S_ACTIVE;
    end

    always_comb begin
        w_fc_valid_nxt = r_fc_valid;
        w_fc_init_nxt  = r_fc_init;
        w_fc_type_nxt  = r_fc_type;
        w_fc_hdr_nxt   = r_fc_hdr;
        w_fc_data_nxt  = r_fc_data;
        if (w_free) begin
            if (w_state_nxt == S_INIT) begin
                w_fc_valid_nxt = 1'b1;
                w_fc_init_nxt  = 1'b1;
                w_fc_type_nxt  = w_ptr_nxt;
            end else begin
                w_fc_init_nxt  = 1'b0;
                w_fc_valid_nxt = |w_avail;
                if      (w_avail[0]) w_fc_type_nxt = FC_P;
                else if (w_avail[1]) w_fc_type_nxt = FC_NP;
                else if (w_avail[2]) w_fc_type_nxt = FC_CPL;
            end
            if (w_fc_valid_nxt) begin
                w_fc_hdr_nxt  = w_ca_hdr[w_fc_type_nxt];
                w_fc_data_nxt = w_ca_data[w_fc_type_nxt];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (arst) begin
            r_fc_valid <= 1'b0;
            r_fc_init  <= 1'b0;
            r_fc_type  <= FC_P;
            r_fc_hdr   <= '0;
            r_fc_data  <= '0;
            r_ovf      <= 1'b0;
            r_ovf_type <= FC_P;
        end else begin
            r_fc_valid <= w_fc_valid_nxt;
            r_fc_init  <= w_fc_init_nxt;
            r_fc_type  <= w_fc_type_nxt;
            r_fc_hdr   <= w_fc_hdr_nxt;
            r_fc_data  <= w_fc_data_nxt;
            r_ovf      <= |w_ovf;
            if (|w_ovf) r_ovf_type <= w_ovf[0] ? FC_P : (w_ovf[1] ? FC_NP : FC_CPL);
        end
    end

    assign fc_if.fc_valid   = r_fc_valid;
    assign fc_if.fc_init    = r_fc_init;
    assign fc_if.fc_type    = r_fc_type;
    assign fc_if.fc_hdr     = r_fc_hdr;
    assign fc_if.fc_data    = r_fc_data;
    assign fc_overflow      = r_ovf;
    assign fc_overflow_type = r_ovf_type;
endmodule
